// File: rtl/ps2_mouse_tx.sv
// PS/2 mouse device-side transmitter.
// Sends one 3-byte standard movement packet to the host per accepted send.
// Both bus lines are open-drain: the block only ever pulls low or releases.
// If the host inhibits the bus mid-byte, the whole packet restarts from byte 0.
module ps2_mouse_tx #(
  parameter int CLK_DIV = 2000,  // sys-clock cycles per PS/2 clock half-period
  parameter int GAP     = 4000   // idle sys-clock cycles between packet bytes
) (
  input  logic        clk100MHz,
  input  logic        rst_n,
  input  logic        send,
  input  logic [11:0] dx,
  input  logic [11:0] dy,
  input  logic [2:0]  btn,
  inout  wire         ps2_clk,
  inout  wire         ps2_data,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_BUS = 3'd1;
  localparam logic [2:0] ST_CLK_HIGH = 3'd2;
  localparam logic [2:0] ST_CLK_LOW  = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  // One shared counter serves every timed state, so it is sized for the longer interval.
  localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       bit_idx_reg;
  logic [1:0]       byte_idx_reg;
  logic [23:0]      pkt_reg;       // {byte2, byte1, byte0}
  logic [10:0]      frame_reg;     // current frame, bit [0] is on the wire
  logic             clk_meta_reg;
  logic             clk_sync_reg;
  logic             done_reg;

  // Saturate each axis to the 9-bit range [-256, 255]; index 0 is X, index 1 is Y.
  logic [11:0] axis_raw   [2];
  logic [8:0]  axis_clamp [2];
  logic        axis_ovf   [2];

  assign axis_raw[0] = dx;
  assign axis_raw[1] = dy;

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic too_pos;
    logic too_neg;
    // A value fits in 9 bits exactly when bits [11:8] are all equal.
    assign too_pos        = ~axis_raw[gi][11] & (axis_raw[gi][10:8] != 3'b000);
    assign too_neg        =  axis_raw[gi][11] & (axis_raw[gi][10:8] != 3'b111);
    assign axis_ovf[gi]   = too_pos | too_neg;
    assign axis_clamp[gi] = too_pos ? 9'h0FF :
                            too_neg ? 9'h100 : axis_raw[gi][8:0];
  end

  logic [7:0] byte0_new;
  assign byte0_new = {axis_ovf[1], axis_ovf[0], axis_clamp[1][8], axis_clamp[0][8],
                      1'b1, btn};

  // Byte selected for the next frame.
  logic [7:0] cur_byte;
  always_comb begin
    cur_byte = pkt_reg[7:0];
    case (byte_idx_reg)
      2'd1:    cur_byte = pkt_reg[15:8];
      2'd2:    cur_byte = pkt_reg[23:16];
      default: cur_byte = pkt_reg[7:0];
    endcase
  end

  // Bring the externally driven PS/2 clock into the system clock domain.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_reg <= 1'b0;
      clk_sync_reg <= 1'b0;
    end else begin
      clk_meta_reg <= ps2_clk;
      clk_sync_reg <= clk_meta_reg;
    end
  end

  // Packet sequencer: bus-idle wait, bit clocking, inter-byte gap, inhibit abort.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      pkt_reg      <= '0;
      frame_reg    <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (send) begin
            pkt_reg      <= {axis_clamp[1][7:0], axis_clamp[0][7:0], byte0_new};
            byte_idx_reg <= 2'd0;
            cnt_reg      <= '0;
            state_reg    <= ST_WAIT_BUS;
          end
        end
        ST_WAIT_BUS: begin
          if (!clk_sync_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DIV_LAST) begin
            cnt_reg     <= '0;
            bit_idx_reg <= 4'd0;
            // stop, odd parity, data LSB first, start
            frame_reg   <= {1'b1, ~^cur_byte, cur_byte, 1'b0};
            state_reg   <= ST_CLK_HIGH;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_CLK_HIGH: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg <= '0;
            if (!clk_sync_reg) begin
              // Host is holding the clock low: give up and resend the packet.
              byte_idx_reg <= 2'd0;
              state_reg    <= ST_WAIT_BUS;
            end else begin
              state_reg <= ST_CLK_LOW;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_CLK_LOW: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_reg <= '0;
            if (bit_idx_reg == 4'd10) begin
              if (byte_idx_reg == 2'd2) begin
                done_reg  <= 1'b1;
                state_reg <= ST_IDLE;
              end else begin
                state_reg <= ST_GAP;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 4'd1;
              frame_reg   <= {1'b0, frame_reg[10:1]};
              state_reg   <= ST_CLK_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg      <= '0;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            state_reg    <= ST_WAIT_BUS;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Line drivers decode straight from state so an asynchronous reset releases them at once.
  logic clk_drive_low;
  logic data_drive_low;
  assign clk_drive_low  = (state_reg == ST_CLK_LOW);
  assign data_drive_low = ((state_reg == ST_CLK_HIGH) || (state_reg == ST_CLK_LOW)) &&
                          !frame_reg[0];

  assign ps2_clk  = clk_drive_low  ? 1'b0 : 1'bz;
  assign ps2_data = data_drive_low ? 1'b0 : 1'bz;

  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;

endmodule

// File: tb/tb_ps2_mouse_tx.sv
// Bench for ps2_mouse_tx: a pulled-up PS/2 bus, a host that samples data on
// falling clock edges and can inhibit, a vector table and a randomized
// reference model.
module tb_ps2_mouse_tx;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 8;
  localparam int BUDGET  = 3000;

  logic        clk100MHz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        send      = 1'b0;
  logic [11:0] dx        = '0;
  logic [11:0] dy        = '0;
  logic [2:0]  btn       = '0;
  logic        busy;
  logic        done;
  logic        host_clk_low = 1'b0;
  logic        clr_req      = 1'b0;
  wire         ps2_clk_w;
  wire         ps2_data_w;

  pullup (ps2_clk_w);
  pullup (ps2_data_w);
  assign ps2_clk_w = host_clk_low ? 1'b0 : 1'bz;

  ps2_mouse_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .clk100MHz (clk100MHz),
    .rst_n     (rst_n),
    .send      (send),
    .dx        (dx),
    .dy        (dy),
    .btn       (btn),
    .ps2_clk   (ps2_clk_w),
    .ps2_data  (ps2_data_w),
    .busy      (busy),
    .done      (done)
  );

  initial forever #5 clk100MHz = ~clk100MHz;

  // Host receiver: collects 11-bit frames; inhibit or a clear request discards everything.
  logic [10:0] frames [$];
  logic [10:0] cur_frame = '0;
  int          bit_cnt   = 0;
  initial forever begin
    @(negedge ps2_clk_w or posedge host_clk_low or posedge clr_req);
    if (host_clk_low || clr_req) begin
      bit_cnt = 0;
      frames.delete();
    end else begin
      cur_frame = {ps2_data_w, cur_frame[10:1]};
      bit_cnt++;
      if (bit_cnt == 11) begin
        frames.push_back(cur_frame);
        bit_cnt = 0;
      end
    end
  end

  int done_cnt   = 0;
  int data_falls = 0;
  initial forever begin
    @(negedge clk100MHz);
    if (done === 1'b1) done_cnt++;
  end
  initial forever begin
    @(negedge ps2_data_w);
    data_falls++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    clr_req = 1'b1;
    #1;
    clr_req = 1'b0;
  endtask

  task automatic send_pkt(input logic [11:0] x, input logic [11:0] y, input logic [2:0] b);
    @(negedge clk100MHz);
    dx   = x;
    dy   = y;
    btn  = b;
    send = 1'b1;
    @(negedge clk100MHz);
    send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start;
    bit seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk100MHz);
      #1;
      if (done_cnt != start) seen = 1'b1;
    end
    chk({name, " done seen"}, int'(seen), 1);
    if (seen) chk({name, " busy at done"}, int'(busy), 0);
  endtask

  task automatic check_pkt(input string name, input logic [23:0] exp_bytes,
                           input logic [2:0] exp_par);
    logic [10:0] f;
    chk({name, " frames"}, frames.size(), 3);
    for (int i = 0; i < 3 && i < frames.size(); i++) begin
      f = frames[i];
      chk($sformatf("%s byte%0d", name, i), int'(f[8:1]), int'(exp_bytes[i*8 +: 8]));
      chk($sformatf("%s parity%0d", name, i), int'(f[9]), int'(exp_par[i]));
      chk($sformatf("%s start/stop%0d", name, i), int'({f[10], f[0]}), 2);
    end
  endtask

  // Reference: clamp with integer arithmetic, assemble bytes, odd parity by counting ones.
  function automatic void ref_pkt(input logic [11:0] x, input logic [11:0] y,
                                  input logic [2:0] b, output logic [23:0] bytes_o,
                                  output logic [2:0] par_o);
    int v [2];
    int c [2];
    int o [2];
    logic [7:0] bb [3];
    v[0] = int'($signed(x));
    v[1] = int'($signed(y));
    for (int k = 0; k < 2; k++) begin
      if (v[k] > 255)       begin c[k] = 255;  o[k] = 1; end
      else if (v[k] < -256) begin c[k] = -256; o[k] = 1; end
      else                  begin c[k] = v[k]; o[k] = 0; end
    end
    bb[0] = 8'(o[1] * 128 + o[0] * 64 + (c[1] < 0 ? 32 : 0) + (c[0] < 0 ? 16 : 0)
               + 8 + int'(b));
    bb[1] = 8'(c[0] & 255);
    bb[2] = 8'(c[1] & 255);
    bytes_o = {bb[2], bb[1], bb[0]};
    for (int k = 0; k < 3; k++) par_o[k] = ($countones(bb[k]) % 2 == 0);
  endfunction

  typedef struct {
    logic [11:0] dx;
    logic [11:0] dy;
    logic [2:0]  btn;
    logic [23:0] exp_bytes;  // {byte2, byte1, byte0}
    logic [2:0]  exp_par;    // bit i = parity of byte i
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input string name, input vec_t v);
    int d0;
    d0 = done_cnt;
    clr();
    send_pkt(v.dx, v.dy, v.btn);
    wait_done(name);
    repeat (20) @(negedge clk100MHz);
    check_pkt(name, v.exp_bytes, v.exp_par);
    chk({name, " done count"}, done_cnt - d0, 1);
  endtask

  initial begin
    int   d0;
    int   f0;
    int   lat;
    bit   found;
    vec_t rv;

    vecs[0] = '{12'd5,    12'hFFD, 3'b001, {8'hFD, 8'h05, 8'h29}, 3'b010};
    vecs[1] = '{12'd300,  12'hE70, 3'b000, {8'h00, 8'hFF, 8'hE8}, 3'b111};
    vecs[2] = '{12'd255,  12'hF00, 3'b111, {8'h00, 8'hFF, 8'h2F}, 3'b110};
    vecs[3] = '{12'd256,  12'd0,   3'b010, {8'h00, 8'hFF, 8'h4A}, 3'b110};
    vecs[4] = '{12'hFFF,  12'd1,   3'b100, {8'h01, 8'hFF, 8'h1C}, 3'b010};
    vecs[5] = '{12'hEFF,  12'd256, 3'b000, {8'hFF, 8'h00, 8'hD8}, 3'b111};

    // Reset state and no spontaneous traffic afterwards.
    repeat (5) @(negedge clk100MHz);
    rst_n = 1'b1;
    clr();
    repeat (50) @(negedge clk100MHz);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset ps2_clk released", int'(ps2_clk_w), 1);
    chk("reset ps2_data released", int'(ps2_data_w), 1);
    chk("reset no frames", frames.size(), 0);

    // Table vectors.
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Randomized packets against the reference model.
    for (int i = 0; i < 8; i++) begin
      rv.dx  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 4095))
                                           : 12'($urandom_range(0, 600)) - 12'd300;
      rv.dy  = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 4095))
                                           : 12'($urandom_range(0, 600)) - 12'd300;
      rv.btn = 3'($urandom_range(0, 7));
      ref_pkt(rv.dx, rv.dy, rv.btn, rv.exp_bytes, rv.exp_par);
      run_vec($sformatf("rand%0d dx=%0d dy=%0d", i, $signed(rv.dx), $signed(rv.dy)), rv);
    end

    // Host holds clock low before the send: nothing on data until release.
    clr();
    host_clk_low = 1'b1;
    d0 = done_cnt;
    f0 = data_falls;
    send_pkt(vecs[0].dx, vecs[0].dy, vecs[0].btn);
    repeat (60) @(negedge clk100MHz);
    #1;
    chk("held busy", int'(busy), 1);
    chk("held no data edge", data_falls - f0, 0);
    host_clk_low = 1'b0;
    lat = 0;
    for (int i = 0; i < 100 && lat == 0; i++) begin
      @(negedge clk100MHz);
      #1;
      if (data_falls != f0) lat = i + 1;
    end
    chk("held start latency", int'(lat >= CLK_DIV && lat <= CLK_DIV + 3), 1);
    wait_done("held");
    repeat (20) @(negedge clk100MHz);
    check_pkt("held", vecs[0].exp_bytes, vecs[0].exp_par);
    chk("held done count", done_cnt - d0, 1);

    // Host inhibit during bit 4 of byte 1: packet restarts from byte 0.
    clr();
    d0 = done_cnt;
    send_pkt(vecs[0].dx, vecs[0].dy, vecs[0].btn);
    found = 1'b0;
    for (int i = 0; i < BUDGET && !found; i++) begin
      @(negedge clk100MHz);
      if (frames.size() == 1 && bit_cnt == 4) found = 1'b1;
    end
    if (found) begin
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
        @(negedge clk100MHz);
        if (ps2_clk_w === 1'b1) found = 1'b1;
      end
    end
    chk("abort trigger reached", int'(found), 1);
    host_clk_low = 1'b1;
    repeat (40) @(negedge clk100MHz);
    #1;
    chk("abort busy held", int'(busy), 1);
    host_clk_low = 1'b0;
    wait_done("abort");
    repeat (20) @(negedge clk100MHz);
    check_pkt("abort", vecs[0].exp_bytes, vecs[0].exp_par);
    chk("abort done count", done_cnt - d0, 1);

    // Second send while busy is ignored.
    clr();
    d0 = done_cnt;
    send_pkt(vecs[0].dx, vecs[0].dy, vecs[0].btn);
    repeat (50) @(negedge clk100MHz);
    #1;
    chk("busy before 2nd send", int'(busy), 1);
    send_pkt(12'd100, 12'd7, 3'b111);
    wait_done("ignore");
    repeat (400) @(negedge clk100MHz);
    check_pkt("ignore", vecs[0].exp_bytes, vecs[0].exp_par);
    chk("ignore done count", done_cnt - d0, 1);

    // Reset in the middle of byte 0.
    clr();
    d0 = done_cnt;
    send_pkt(vecs[0].dx, vecs[0].dy, vecs[0].btn);
    found = 1'b0;
    for (int i = 0; i < BUDGET && !found; i++) begin
      @(negedge clk100MHz);
      if (frames.size() == 0 && bit_cnt == 3 && ps2_clk_w === 1'b0 && ps2_data_w === 1'b0)
        found = 1'b1;
    end
    chk("midreset trigger reached", int'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset ps2_clk released", int'(ps2_clk_w), 1);
    chk("midreset ps2_data released", int'(ps2_data_w), 1);
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    repeat (3) @(negedge clk100MHz);
    rst_n = 1'b1;
    clr();
    f0 = data_falls;
    repeat (300) @(negedge clk100MHz);
    #1;
    chk("post-reset no frames", frames.size(), 0);
    chk("post-reset no bits", bit_cnt, 0);
    chk("post-reset no data edge", data_falls - f0, 0);
    chk("post-reset no done", done_cnt - d0, 0);
    run_vec("after reset", vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
